// File: rtl/switch_out_sched_if.sv
// Bus bundle of the per-port frame scheduler: descriptor queues, cell buffer
// read port, output cell FIFO write port and status.
interface switch_out_sched_if #(
  parameter int NQ = 4,
  parameter int AW = 10
);
  logic [NQ-1:0]    q_empty;
  logic [NQ*16-1:0] q_desc;
  logic [NQ-1:0]    q_rd;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [127:0]     mem_dout;
  logic             o_cell_data_fifo_wr;
  logic [127:0]     o_cell_data_fifo_din;
  logic             o_cell_data_first;
  logic             o_cell_data_last;
  logic             o_cell_data_fifo_bp;
  logic             sched_busy;
  logic [2:0]       sched_qsel;

  modport master (
    input  q_empty, q_desc, mem_dout, o_cell_data_fifo_bp,
    output q_rd, mem_rd, mem_addr, o_cell_data_fifo_wr, o_cell_data_fifo_din,
           o_cell_data_first, o_cell_data_last, sched_busy, sched_qsel
  );

  modport slave (
    output q_empty, q_desc, mem_dout, o_cell_data_fifo_bp,
    input  q_rd, mem_rd, mem_addr, o_cell_data_fifo_wr, o_cell_data_fifo_din,
           o_cell_data_first, o_cell_data_last, sched_busy, sched_qsel
  );
endinterface

// File: rtl/switch_out_sched.sv
// Per-output-port frame scheduler: weighted round robin over NQ descriptor
// queues, streaming whole frames from the cell buffer into the output FIFO.
module switch_out_sched #(
  parameter int              NQ      = 4,
  parameter int              AW      = 10,
  parameter logic [4*NQ-1:0] WEIGHTS = 16'h1248
) (
  input  logic               clk,
  input  logic               rst,
  switch_out_sched_if.master bus
);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int CW = QW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t        state_r, state_n_s;
  logic [3:0]    credit_r   [NQ];
  logic [3:0]    credit_n_s [NQ];
  logic [QW-1:0] rr_ptr_r, rr_ptr_n_s;
  logic [AW-1:0] addr_r, addr_n_s;
  logic [6:0]    remain_r, remain_n_s;
  logic          is_first_r, is_first_n_s;
  logic [2:0]    qsel_r, qsel_n_s;
  logic          wr_r, first_r, last_r;

  logic [NQ-1:0] eligible_s;
  logic          any_pending_s;
  logic          grant_found_s;
  logic [QW-1:0] grant_idx_s;
  logic [QW-1:0] grant_next_s;
  logic [CW-1:0] cand_s;
  logic [15:0]   grant_desc_s;
  logic [NQ-1:0] q_rd_s;
  logic          mem_rd_s;
  logic          is_last_s;

  // A programmed weight of 0 would starve the queue, so it counts as 1
  function automatic logic [3:0] weight_of(input int idx);
    logic [3:0] w;
    w = WEIGHTS[4*idx +: 4];
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

  // Eligibility and round-robin search; descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    eligible_s  = '0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int i = 0; i < NQ; i++) begin
      eligible_s[i] = !bus.q_empty[i] && (credit_r[i] != 4'd0);
    end
    for (int off = NQ - 1; off >= 0; off--) begin
      cand_s = {1'b0, rr_ptr_r} + CW'(off);
      cand_s = (cand_s >= CW'(NQ)) ? (cand_s - CW'(NQ)) : cand_s;
      if (eligible_s[cand_s[QW-1:0]]) begin
        grant_idx_s = cand_s[QW-1:0];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    grant_found_s = |eligible_s;
    any_pending_s = |(~bus.q_empty);
    grant_desc_s  = bus.q_desc[16*grant_idx_s +: 16];
    grant_next_s  = (grant_idx_s == QW'(NQ - 1)) ? '0 : (grant_idx_s + QW'(1));
    is_last_s     = (remain_r == 7'd1);
  end

  // Next-state logic and strobes of the IDLE/ARB/XFER controller
  always_comb begin
    state_n_s    = state_r;
    credit_n_s   = credit_r;
    rr_ptr_n_s   = rr_ptr_r;
    addr_n_s     = addr_r;
    remain_n_s   = remain_r;
    is_first_n_s = is_first_r;
    qsel_n_s     = qsel_r;
    q_rd_s       = '0;
    mem_rd_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_pending_s && !bus.o_cell_data_fifo_bp) begin
          state_n_s = ARB;
        end else begin
          state_n_s = IDLE;
        end
      end
      ARB: begin
        if (grant_found_s) begin
          q_rd_s[grant_idx_s]     = 1'b1;
          addr_n_s                = AW'(grant_desc_s[9:0]);
          remain_n_s              = (grant_desc_s[15:10] == 6'd0) ? 7'd64 : {1'b0, grant_desc_s[15:10]};
          is_first_n_s            = 1'b1;
          qsel_n_s                = 3'(grant_idx_s);
          credit_n_s[grant_idx_s] = credit_r[grant_idx_s] - 4'd1;
          // Stay on the queue while it still has credit, else move past it
          if (credit_r[grant_idx_s] == 4'd1) begin
            rr_ptr_n_s = grant_next_s;
          end else begin
            rr_ptr_n_s = grant_idx_s;
          end
          state_n_s = XFER;
        end else if (any_pending_s) begin
          for (int i = 0; i < NQ; i++) begin
            credit_n_s[i] = weight_of(i);
          end
          state_n_s = ARB;
        end else begin
          state_n_s = IDLE;
        end
      end
      XFER: begin
        if (!bus.o_cell_data_fifo_bp) begin
          mem_rd_s     = 1'b1;
          addr_n_s     = addr_r + AW'(1);
          remain_n_s   = remain_r - 7'd1;
          is_first_n_s = 1'b0;
          if (is_last_s) begin
            state_n_s = IDLE;
          end else begin
            state_n_s = XFER;
          end
        end else begin
          mem_rd_s  = 1'b0;
          state_n_s = XFER;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Controller state, credits, round-robin pointer and latched descriptor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      addr_r     <= '0;
      remain_r   <= 7'd0;
      is_first_r <= 1'b0;
      qsel_r     <= 3'd0;
      for (int i = 0; i < NQ; i++) begin
        credit_r[i] <= weight_of(i);
      end
    end else begin
      state_r    <= state_n_s;
      rr_ptr_r   <= rr_ptr_n_s;
      addr_r     <= addr_n_s;
      remain_r   <= remain_n_s;
      is_first_r <= is_first_n_s;
      qsel_r     <= qsel_n_s;
      for (int i = 0; i < NQ; i++) begin
        credit_r[i] <= credit_n_s[i];
      end
    end
  end

  // Output stage aligned with the one-cycle cell buffer read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      wr_r    <= mem_rd_s;
      first_r <= mem_rd_s & is_first_r;
      last_r  <= mem_rd_s & is_last_s;
    end
  end

  assign bus.q_rd                 = q_rd_s;
  assign bus.mem_rd               = mem_rd_s;
  assign bus.mem_addr             = addr_r;
  assign bus.o_cell_data_fifo_wr  = wr_r;
  assign bus.o_cell_data_fifo_din = bus.mem_dout;
  assign bus.o_cell_data_first    = first_r;
  assign bus.o_cell_data_last     = last_r;
  assign bus.sched_busy           = (state_r != IDLE);
  assign bus.sched_qsel           = qsel_r;
endmodule

// File: tb/tb_switch_out_sched.sv
// Self-checking bench for switch_out_sched: table of single-frame vectors plus
// hand sequences for WRR order, backpressure and reset mid-frame.
module tb_switch_out_sched;
  localparam int NQ = 4;
  localparam int AW = 10;

  typedef struct {
    int q;
    int cnt;
    int addr;
    int cells;
    int last_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp  = 1'b0;
  always #5 clk = ~clk;

  switch_out_sched_if #(.NQ(NQ), .AW(AW)) bus ();
  switch_out_sched #(.NQ(NQ), .AW(AW), .WEIGHTS(16'h1248)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [127:0] mem_q;
  logic [7:0]   qcnt     [NQ];
  logic [15:0]  qdesc    [NQ];
  logic [7:0]   load_val [NQ];
  logic         load_req;

  // cell buffer model: one-cycle read latency, data word carries its address
  always @(posedge clk) begin
    if (bus.mem_rd) mem_q <= {118'd0, bus.mem_addr};
  end
  assign bus.mem_dout            = mem_q;
  assign bus.o_cell_data_fifo_bp = bp;

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (load_req) qcnt[i] <= load_val[i];
      else if (bus.q_rd[i] && qcnt[i] != 8'd0) qcnt[i] <= qcnt[i] - 8'd1;
    end
  end

  always_comb begin
    bus.q_empty = '0;
    bus.q_desc  = '0;
    for (int i = 0; i < NQ; i++) begin
      bus.q_empty[i]         = (qcnt[i] == 8'd0);
      bus.q_desc[16*i +: 16] = qdesc[i];
    end
  end

  int n_cmp, n_bad;
  int cyc, nrd, nwr, nfirst, nlast, cell_err, qrd_cnt, pos, frame_len;
  int qrd_cyc, rd_cyc, wr_cyc, last_grant, qsel_at_rd, last_wr_addr;
  bit chk_addr;
  logic [9:0] exp_rd_addr, exp_wr_addr;
  int wrr_exp [15];
  vec_t vecs [5];
  int bp_cnt, bp_viol, hold_err;
  bit bp_done;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int outputs_vec();
    return int'({bus.q_rd, bus.mem_rd, bus.mem_addr, bus.o_cell_data_fifo_wr,
                 bus.o_cell_data_first, bus.o_cell_data_last, bus.sched_busy, bus.sched_qsel});
  endfunction

  task automatic frame_begin(input int start, input int len, input bit do_addr);
    cyc = 0; nrd = 0; nwr = 0; nfirst = 0; nlast = 0; cell_err = 0; qrd_cnt = 0; pos = 0;
    qrd_cyc = -1; rd_cyc = -1; wr_cyc = -1; last_grant = -1; qsel_at_rd = -1; last_wr_addr = -1;
    frame_len = len; chk_addr = do_addr;
    exp_rd_addr = 10'(start); exp_wr_addr = 10'(start);
  endtask

  task automatic sample();
    if (bus.q_rd != '0) begin
      qrd_cnt++;
      if (qrd_cyc < 0) qrd_cyc = cyc;
      if ($countones(bus.q_rd) != 1) cell_err++;
      for (int i = 0; i < NQ; i++) if (bus.q_rd[i]) last_grant = i;
    end
    if (bus.mem_rd) begin
      if (rd_cyc < 0) begin rd_cyc = cyc; qsel_at_rd = int'(bus.sched_qsel); end
      if (chk_addr && bus.mem_addr != exp_rd_addr) cell_err++;
      exp_rd_addr = exp_rd_addr + 10'd1;
      nrd++;
    end
    if (bus.o_cell_data_fifo_wr) begin
      if (wr_cyc < 0) wr_cyc = cyc;
      if (chk_addr && bus.o_cell_data_fifo_din != {118'd0, exp_wr_addr}) cell_err++;
      if (bus.o_cell_data_first != (pos == 0)) cell_err++;
      if (bus.o_cell_data_last != (pos == frame_len - 1)) cell_err++;
      nfirst += int'(bus.o_cell_data_first);
      nlast  += int'(bus.o_cell_data_last);
      last_wr_addr = int'(bus.o_cell_data_fifo_din[9:0]);
      exp_wr_addr = exp_wr_addr + 10'd1;
      nwr++;
      pos = bus.o_cell_data_last ? 0 : pos + 1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bp = 1'b0; load_req = 1'b1;
    for (int i = 0; i < NQ; i++) load_val[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1; load_req = 1'b0; rst = 1'b0;
  endtask

  task automatic load_all(input int n);
    for (int i = 0; i < NQ; i++) begin
      qdesc[i] = {6'd1, 10'(16 * i)};
      load_val[i] = 8'(n);
    end
    load_req = 1'b1;
  endtask

  // grants of single-cell frames against the 8/4/2/1 round pattern
  task automatic run_wrr(input string tag, input int n);
    int got = 0;
    int prev = -1;
    int budget = 0;
    frame_begin(0, 1, 1'b0);
    while (got < n && budget < 8 * n) begin
      @(negedge clk);
      sample();
      if (qrd_cnt != got) begin
        check($sformatf("%s_grant%0d", tag, got), last_grant, wrr_exp[got % 15]);
        if (got > 0) check($sformatf("%s_gap%0d", tag, got), cyc - 1 - prev, (got % 15 == 0) ? 4 : 3);
        prev = cyc - 1;
        got++;
      end
      budget++;
    end
    check({tag, "_grant_count"}, got, n);
    check({tag, "_cell_err"}, cell_err, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; load_req = 1'b1;
    for (int i = 0; i < NQ; i++) begin load_val[i] = 8'd0; qdesc[i] = 16'd0; end
    wrr_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3};
    vecs = '{
      '{0, 3, 'h3FE,  3, 'h000},
      '{1, 1, 'h005,  1, 'h005},
      '{2, 0, 'h100, 64, 'h13F},
      '{3, 5, 'h3FD,  5, 'h001},
      '{0, 2, 'h200,  2, 'h201}
    };

    do_reset();
    @(negedge clk);
    check("reset_outputs", outputs_vec(), 0);

    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      qdesc[vecs[v].q] = {6'(vecs[v].cnt), 10'(vecs[v].addr)};
      for (int i = 0; i < NQ; i++) load_val[i] = 8'd0;
      load_val[vecs[v].q] = 8'd1;
      load_req = 1'b1;
      @(posedge clk); #1; load_req = 1'b0;
      frame_begin(vecs[v].addr, vecs[v].cells, 1'b1);
      repeat (vecs[v].cells + 6) begin @(negedge clk); sample(); end
      check($sformatf("v%0d_qrd_count", v), qrd_cnt, 1);
      check($sformatf("v%0d_grant", v), last_grant, vecs[v].q);
      check($sformatf("v%0d_qrd_lat", v), qrd_cyc, 1);
      check($sformatf("v%0d_rd_lat", v), rd_cyc, 2);
      check($sformatf("v%0d_wr_lat", v), wr_cyc, 3);
      check($sformatf("v%0d_qsel", v), qsel_at_rd, vecs[v].q);
      check($sformatf("v%0d_reads", v), nrd, vecs[v].cells);
      check($sformatf("v%0d_writes", v), nwr, vecs[v].cells);
      check($sformatf("v%0d_firsts", v), nfirst, 1);
      check($sformatf("v%0d_lasts", v), nlast, 1);
      check($sformatf("v%0d_cell_err", v), cell_err, 0);
      check($sformatf("v%0d_last_addr", v), last_wr_addr, vecs[v].last_addr);
      check($sformatf("v%0d_busy_end", v), int'(bus.sched_busy), 0);
    end

    // all queues backlogged: two full WRR rounds
    do_reset();
    @(posedge clk); #1; load_all(40);
    @(posedge clk); #1; load_req = 1'b0;
    run_wrr("wrr", 30);

    // backpressure: held in IDLE, then a 5-cycle pause inside a 4-cell frame
    do_reset();
    @(posedge clk); #1;
    bp = 1'b1;
    qdesc[1] = {6'd4, 10'h010};
    for (int i = 0; i < NQ; i++) load_val[i] = 8'd0;
    load_val[1] = 8'd1; load_req = 1'b1;
    @(posedge clk); #1; load_req = 1'b0;
    frame_begin('h010, 4, 1'b1);
    repeat (4) begin @(negedge clk); sample(); end
    check("bp_idle_qrd", qrd_cnt, 0);
    check("bp_idle_busy", int'(bus.sched_busy), 0);
    bp_cnt = 0; bp_done = 1'b0; bp_viol = 0; hold_err = 0;
    @(posedge clk); #1; bp = 1'b0;
    for (int it = 0; it < 30; it++) begin
      @(negedge clk); sample();
      if (bp && bus.mem_rd) bp_viol++;
      if (bp && (bus.mem_addr != 10'h012 || !bus.sched_busy)) hold_err++;
      @(posedge clk); #1;
      if (bp_cnt > 0) begin
        bp_cnt--;
        if (bp_cnt == 0) bp = 1'b0;
      end else if (nrd == 2 && !bp_done) begin
        bp = 1'b1; bp_cnt = 5; bp_done = 1'b1;
      end
    end
    check("bp_applied", int'(bp_done), 1);
    check("bp_rd_during_bp", bp_viol, 0);
    check("bp_state_held", hold_err, 0);
    check("bp_reads", nrd, 4);
    check("bp_writes", nwr, 4);
    check("bp_firsts", nfirst, 1);
    check("bp_lasts", nlast, 1);
    check("bp_cell_err", cell_err, 0);
    check("bp_last_addr", last_wr_addr, 'h013);

    // reset in the middle of a Q1 frame, then Q0 must lead a fresh round
    do_reset();
    @(posedge clk); #1;
    qdesc[1] = {6'd10, 10'h080};
    for (int i = 0; i < NQ; i++) load_val[i] = 8'd0;
    load_val[1] = 8'd1; load_req = 1'b1;
    @(posedge clk); #1; load_req = 1'b0;
    frame_begin('h080, 10, 1'b1);
    for (int b = 0; b < 20 && nrd < 3; b++) begin @(negedge clk); sample(); end
    check("rst_pre_reads", nrd, 3);
    check("rst_pre_cell_err", cell_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", outputs_vec(), 0);
    load_all(40);
    repeat (2) @(posedge clk);
    #1; load_req = 1'b0; rst = 1'b0;
    run_wrr("rst_wrr", 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
